// File: rtl/foo_pkg.sv
// Shared types for the foo lane-pair serialiser: lane-pair word layout and output FSM states.
package foo_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned NUM_LANES = 2;

    typedef logic [NUM_LANES-1:0][WORD_W-1:0] lane_pair_t;

    typedef enum logic [0:0] {
        ST_LANE0,
        ST_LANE1
    } out_state_t;

endpackage

// File: rtl/foo_pair_fifo.sv
// Single-clock FIFO of lane pairs; a push into a full FIFO is honoured only alongside a pop.
module foo_pair_fifo
    import foo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  lane_pair_t                 wdata_i,
    input  logic                       pop_i,
    output lane_pair_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    lane_pair_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/foo_pair_serializer.sv
// Aligns the foo issue strobe with the lane results, buffers lane pairs and streams them
// out one word at a time (lane 0 then lane 1); overflow is counted, never back-pressured.
module foo_pair_serializer
    import foo_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FOO_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lane,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic       x_valid;
    lane_pair_t pair_in, head;
    logic       push, pop, slot_free;
    logic [AW:0] fifo_count;

    out_state_t       state_q, state_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    if (FOO_LATENCY == 0) begin : g_no_dly
        assign x_valid = a_valid;
    end else begin : g_dly
        logic [FOO_LATENCY-1:0] dly_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= a_valid;
                for (int unsigned i = 1; i < FOO_LATENCY; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign x_valid = dly_q[FOO_LATENCY-1];
    end

    assign pair_in[0] = WORD_W'(x0);
    assign pair_in[1] = WORD_W'(x1);

    // A pop in this cycle frees the head slot in time for a same-cycle push.
    assign slot_free = (fifo_count < FULL_CNT) || pop;
    assign push      = x_valid && slot_free;

    foo_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (pair_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_lane  = 1'b0;
        out_data  = '0;
        pop       = 1'b0;
        unique case (state_q)
            ST_LANE0: begin
                out_valid = !empty;
                if (!empty) begin
                    out_data = WIDTH'(head[0]);
                    if (out_ready) state_d = ST_LANE1;
                end
            end
            ST_LANE1: begin
                out_valid = 1'b1;
                out_lane  = 1'b1;
                out_data  = WIDTH'(head[1]);
                if (out_ready) begin
                    pop     = 1'b1;
                    state_d = ST_LANE0;
                end
            end
            default: state_d = ST_LANE0;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (x_valid && !slot_free && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LANE0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_foo_pair_serializer.sv
// Directed self-checking bench for foo_pair_serializer (DEPTH=4, FOO_LATENCY=1).
module tb_foo_pair_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [63:0] x0, x1;
    logic [63:0] out_data;
    logic        out_lane, out_valid, out_ready;
    logic        full, empty;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] A0 = 64'hAAA0_0000_0000_0000, A1 = 64'hAAA1_0000_0000_0000;
    localparam logic [63:0] C0 = 64'hCCC0_0000_0000_0000, C1 = 64'hCCC1_0000_0000_0000;
    localparam logic [63:0] D0 = 64'hDDD0_0000_0000_0000, D1 = 64'hDDD1_0000_0000_0000;
    localparam logic [63:0] E0 = 64'hEEE0_0000_0000_0000, E1 = 64'hEEE1_0000_0000_0000;
    localparam logic [63:0] F0 = 64'hFFF0_0000_0000_0000, F1 = 64'hFFF1_0000_0000_0000;

    foo_pair_serializer #(
        .WIDTH       (64),
        .DEPTH       (4),
        .FOO_LATENCY (1),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .x0         (x0),
        .x1         (x1),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic lane, input logic [63:0] data);
        chk(tag, {6'd0, out_valid, out_lane, out_data}, {6'd0, 1'b1, lane, data});
    endtask

    task automatic step(input logic av, input logic [63:0] v0, input logic [63:0] v1);
        a_valid = av;
        x0      = v0;
        x1      = v1;
        @(posedge clk);
        #1;
    endtask

    // Expects pairs first..last of a group, sink held ready, no gaps between words.
    task automatic drain(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                         input int first, input int last);
        out_ready = 1'b1;
        for (int i = first; i <= last; i++) begin
            chk_word(tag, 1'b0, b0 + 64'(i));
            step(1'b0, '0, '0);
            chk_word(tag, 1'b1, b1 + 64'(i));
            step(1'b0, '0, '0);
        end
    endtask

    initial begin
        logic [63:0] refq[$];
        logic [63:0] expw;
        int          got, stalls;

        rst = 1'b1; out_ready = 1'b1;
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        rst = 1'b0;
        chk("rst_valid", 72'(out_valid), 72'd0);
        chk("rst_lane",  72'(out_lane),  72'd0);
        chk("rst_data",  72'(out_data),  72'd0);
        chk("rst_full",  72'(full),      72'd0);
        chk("rst_empty", 72'(empty),     72'd1);
        chk("rst_drop",  72'(drop_count), 72'd0);

        // Single strobe: cycles 0-4 idle, strobe in 5, lane data in 6.
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0);
        step(1'b1, '0, '0);
        step(1'b0, 64'h1111, 64'h2222);
        chk_word("single_l0", 1'b0, 64'h1111);
        step(1'b0, '0, '0);
        chk_word("single_l1", 1'b1, 64'h2222);
        step(1'b0, '0, '0);
        chk("single_idle",  72'(out_valid), 72'd0);
        chk("single_zero",  72'(out_data),  72'd0);
        chk("single_empty", 72'(empty),     72'd1);

        // Back-pressure: four strobes two cycles apart fill the FIFO.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, '0, '0);
            step(1'b0, A0 + 64'(i), A1 + 64'(i));
            chk_word("bp_hold", 1'b0, A0 + 64'd1);
        end
        chk("bp_full", 72'(full), 72'd1);
        drain("bp_word", A0, A1, 1, 4);
        chk("bp_drop",  72'(drop_count), 72'd0);
        chk("bp_empty", 72'(empty), 72'd1);

        // Overflow: six back-to-back strobes into a stalled sink, last two dropped.
        out_ready = 1'b0;
        step(1'b1, '0, '0);
        for (int i = 1; i <= 5; i++) step(1'b1, C0 + 64'(i), C1 + 64'(i));
        step(1'b0, C0 + 64'd6, C1 + 64'd6);
        chk("ovf_drop", 72'(drop_count), 72'd2);
        chk("ovf_full", 72'(full), 72'd1);
        drain("ovf_word", C0, C1, 1, 4);
        chk("ovf_empty", 72'(empty), 72'd1);

        // Push on full, coinciding with the lane-1 handshake that pops the head.
        out_ready = 1'b0;
        step(1'b1, '0, '0);
        for (int i = 1; i <= 3; i++) step(1'b1, D0 + 64'(i), D1 + 64'(i));
        step(1'b0, D0 + 64'd4, D1 + 64'd4);
        chk("pof_full0", 72'(full), 72'd1);
        out_ready = 1'b1;
        chk_word("pof_l0", 1'b0, D0 + 64'd1);
        step(1'b1, '0, '0);
        chk_word("pof_l1", 1'b1, D1 + 64'd1);
        chk("pof_full1", 72'(full), 72'd1);
        step(1'b0, D0 + 64'd5, D1 + 64'd5);
        chk("pof_full2", 72'(full), 72'd1);
        chk("pof_drop",  72'(drop_count), 72'd2);
        drain("pof_word", D0, D1, 2, 5);
        chk("pof_empty", 72'(empty), 72'd1);

        // Wrap-around: 20 pairs at one strobe per two cycles, at most four stall cycles.
        got = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
            logic        av;
            logic [63:0] v0, v1;
            av = (cyc % 2 == 0) && (cyc / 2 < 20);
            v0 = '0;
            v1 = '0;
            if ((cyc % 2 == 1) && (cyc / 2 < 20)) begin
                v0 = E0 + 64'(cyc / 2);
                v1 = E1 + 64'(cyc / 2);
                refq.push_back(v0);
                refq.push_back(v1);
            end
            out_ready = 1'b1;
            if (stalls < 4 && $urandom_range(0, 7) == 0) begin
                out_ready = 1'b0;
                stalls++;
            end
            if (out_valid && out_ready) begin
                if (refq.size() == 0) begin
                    chk("wrap_extra", 72'(out_data), 72'd0);
                end else begin
                    expw = refq.pop_front();
                    chk_word("wrap_word", got[0], expw);
                end
                got++;
            end
            step(av, v0, v1);
        end
        chk("wrap_count", 72'(got), 72'd40);
        chk("wrap_drop",  72'(drop_count), 72'd2);
        chk("wrap_empty", 72'(empty), 72'd1);

        // Mid-operation reset in lane 1 with three pairs buffered and a strobe in flight.
        out_ready = 1'b0;
        step(1'b1, '0, '0);
        step(1'b1, F0 + 64'd1, F1 + 64'd1);
        step(1'b1, F0 + 64'd2, F1 + 64'd2);
        step(1'b0, F0 + 64'd3, F1 + 64'd3);
        out_ready = 1'b1;
        step(1'b1, '0, '0);
        chk_word("mid_l1", 1'b1, F1 + 64'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        step(1'b0, F0 + 64'd4, F1 + 64'd4);
        rst = 1'b0;
        chk("mid_valid", 72'(out_valid), 72'd0);
        chk("mid_empty", 72'(empty), 72'd1);
        chk("mid_drop",  72'(drop_count), 72'd0);
        chk("mid_full",  72'(full), 72'd0);
        chk("mid_lane",  72'(out_lane), 72'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, F0 + 64'd9, F1 + 64'd9);
        chk("mid_flush_valid", 72'(out_valid), 72'd0);
        chk("mid_flush_empty", 72'(empty), 72'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
